// File: rtl/apb_transfer_sequencer_if.sv
// Bus bundle between the AHB front end, apb_transfer_sequencer and the APB peripherals.
// The master view belongs to the sequencer; the slave view is its AHB/APB counterpart.
interface apb_transfer_sequencer_if;
    logic        valid;
    logic        hwrite;
    logic [31:0] haddr1;
    logic [31:0] hwdata;
    logic [2:0]  temp_selx;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [2:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    modport master (
        input  valid, hwrite, haddr1, hwdata, temp_selx, prdata, pready, pslverr,
        output pselx, penable, pwrite, paddr, pwdata, hreadyout, hresp, hrdata
    );

    modport slave (
        output valid, hwrite, haddr1, hwdata, temp_selx, prdata, pready, pslverr,
        input  pselx, penable, pwrite, paddr, pwdata, hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/apb_transfer_sequencer.sv
// Turns accepted AHB transfers into APB SETUP/ACCESS phases, with AHB wait states,
// the two-cycle AHB ERROR response and an optional abort of hung APB accesses.
module apb_transfer_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic                     hclk,
    input  logic                     hresetn,
    apb_transfer_sequencer_if.master bus
);
    localparam int              CW         = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LAST_WAIT  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [1:0]      RESP_OKAY  = 2'b00;
    localparam logic [1:0]      RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2} state_t;

    state_t        state;
    logic [2:0]    sel_q;
    logic [CW-1:0] wait_cnt;
    logic          access_done;
    logic          access_err;
    logic          timeout_hit;
    logic          can_accept;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        access_done   = 1'b0;
        access_err    = 1'b0;
        timeout_hit   = 1'b0;
        bus.hrdata    = '0;
        if (state == ACCESS) begin
            access_done = bus.pready && !bus.pslverr;
            access_err  = bus.pready && bus.pslverr;
            // The current wait cycle is the TIMEOUT-th one; a pready in it still completes.
            timeout_hit = !bus.pready && (TIMEOUT != 0) && (wait_cnt == LAST_WAIT);
            if (access_done && !bus.pwrite) bus.hrdata = bus.prdata;
        end
        can_accept    = (state == IDLE) || (state == ERR2) || access_done;
        bus.hreadyout = can_accept;
        bus.hresp     = ((state == ERR1) || (state == ERR2)) ? RESP_ERROR : RESP_OKAY;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state       <= IDLE;
            sel_q       <= '0;
            wait_cnt    <= '0;
            bus.pselx   <= '0;
            bus.penable <= 1'b0;
            bus.pwrite  <= 1'b0;
            bus.paddr   <= '0;
            bus.pwdata  <= '0;
        end else if (can_accept) begin
            // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
            bus.penable <= 1'b0;
            if (bus.valid) begin
                bus.paddr  <= bus.haddr1;
                bus.pwrite <= bus.hwrite;
                sel_q      <= bus.temp_selx;
                if (bus.temp_selx == 3'b000) begin
                    state     <= ERR1;
                    bus.pselx <= '0;
                end else if (bus.hwrite) begin
                    state     <= WWAIT;
                    bus.pselx <= '0;
                end else begin
                    state     <= SETUP;
                    bus.pselx <= bus.temp_selx;
                end
            end else begin
                state     <= IDLE;
                bus.pselx <= '0;
            end
        end else begin
            unique case (state)
                WWAIT: begin
                    bus.pwdata <= bus.hwdata;
                    bus.pselx  <= sel_q;
                    state      <= SETUP;
                end
                SETUP: begin
                    bus.penable <= 1'b1;
                    wait_cnt    <= '0;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (access_err || timeout_hit) begin
                        state       <= ERR1;
                        bus.pselx   <= '0;
                        bus.penable <= 1'b0;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ERR1:    state <= ERR2;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_transfer_sequencer.sv
// Randomised scoreboard bench for apb_transfer_sequencer: a driver issues AHB transfers and
// plays the APB slave, a transaction-level model predicts each outcome, a monitor compares.
module tb_apb_transfer_sequencer;
    localparam int TIMEOUT = 4;
    localparam int MAX_CYCLES = 4000;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [2:0]  sel;
        int          nwait;
        logic        slverr;
    } txn_t;

    typedef struct {
        int          accept;
        int          setup;
        int          done;
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        write;
        logic [1:0]  resp;
    } exp_t;

    logic hclk;
    logic hresetn;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    bit   mon_en = 0;
    txn_t plan[$];
    exp_t resp_q[$];
    exp_t apb_q[$];

    apb_transfer_sequencer_if bus ();

    apb_transfer_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;
    always @(posedge hclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pselx"},     32'(bus.pselx),     32'h0);
        check({tag, "_penable"},   32'(bus.penable),   32'h0);
        check({tag, "_pwrite"},    32'(bus.pwrite),    32'h0);
        check({tag, "_paddr"},     bus.paddr,          32'h0);
        check({tag, "_pwdata"},    bus.pwdata,         32'h0);
        check({tag, "_hreadyout"}, 32'(bus.hreadyout), 32'h1);
        check({tag, "_hresp"},     32'(bus.hresp),     32'h0);
        check({tag, "_hrdata"},    bus.hrdata,         32'h0);
    endtask

    task automatic add_txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input logic [2:0] s, input int nw,
                           input logic se);
        txn_t t;
        t.write = w; t.addr = a; t.wdata = wd; t.rdata = rd;
        t.sel = s; t.nwait = nw; t.slverr = se;
        plan.push_back(t);
    endtask

    // Transaction-level prediction: cycle offsets counted from the accept cycle.
    function automatic exp_t model(input txn_t t, input int acc);
        exp_t e;
        e.accept = acc;
        e.sel    = t.sel;
        e.addr   = t.addr;
        e.wdata  = t.wdata;
        e.write  = t.write;
        e.rdata  = 32'h0;
        e.resp   = 2'b00;
        e.setup  = acc + (t.write ? 2 : 1);
        if (t.sel == 3'b000) begin
            e.resp = 2'b01;
            e.done = acc + 2;
        end else if (TIMEOUT != 0 && t.nwait >= TIMEOUT) begin
            e.resp = 2'b01;
            e.done = e.setup + TIMEOUT + 2;
        end else if (t.slverr) begin
            e.resp = 2'b01;
            e.done = e.setup + t.nwait + 3;
        end else begin
            e.done = e.setup + t.nwait + 1;
            if (!t.write) e.rdata = t.rdata;
        end
        return e;
    endfunction

    logic [1:0] prev_hresp = 2'b00;
    logic       prev_hready = 1'b1;

    always @(negedge hclk) begin : monitor
        exp_t e;
        if (mon_en) begin
            if (bus.pselx != 3'b000 && !bus.penable) begin
                if (apb_q.size() == 0) begin
                    check("unexpected_setup_pselx", 32'(bus.pselx), 32'h0);
                end else begin
                    e = apb_q.pop_front();
                    check("setup_cycle", 32'(cyc), 32'(e.setup));
                    check("pselx", 32'(bus.pselx), 32'(e.sel));
                    check("paddr", bus.paddr, e.addr);
                    check("pwrite", 32'(bus.pwrite), 32'(e.write));
                    if (e.write) check("pwdata", bus.pwdata, e.wdata);
                end
            end
            if (bus.hreadyout && resp_q.size() > 0 && resp_q[0].accept < cyc) begin
                e = resp_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.done));
                check("hresp", 32'(bus.hresp), 32'(e.resp));
                check("hrdata", bus.hrdata, e.rdata);
                if (e.resp == 2'b01) begin
                    check("err1_hresp", 32'(prev_hresp), 32'h1);
                    check("err1_hreadyout", 32'(prev_hready), 32'h0);
                end
            end else if (bus.hreadyout) begin
                check("idle_hresp", 32'(bus.hresp), 32'h0);
                check("idle_hrdata", bus.hrdata, 32'h0);
            end else begin
                check("stall_hrdata", bus.hrdata, 32'h0);
            end
        end
        prev_hresp  = bus.hresp;
        prev_hready = bus.hreadyout;
    end

    initial begin : stimulus
        txn_t        t;
        txn_t        cur;
        exp_t        e;
        int          acc_cnt;
        int          waited;
        int          cycles;
        int          issued;
        int          n_directed;
        int          k;
        bit          last_wr;
        logic [31:0] last_wdata;

        hresetn       = 1'b0;
        bus.valid     = 1'b0;
        bus.hwrite    = 1'b0;
        bus.haddr1    = 32'h0;
        bus.hwdata    = 32'h0;
        bus.temp_selx = 3'b000;
        bus.prdata    = 32'h0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        cur           = '{default: 0};
        repeat (2) @(negedge hclk);
        check_reset_outputs("por");
        @(posedge hclk); #1 hresetn = 1'b1;

        // Reset asserted in the middle of a stalled read ACCESS.
        @(posedge hclk); #1;
        bus.valid = 1'b1; bus.hwrite = 1'b0; bus.haddr1 = 32'h0000_0044; bus.temp_selx = 3'b100;
        @(posedge hclk); #1;
        bus.valid = 1'b0;
        waited = 0;
        while (!bus.penable && waited < 8) begin
            @(posedge hclk); #1;
            waited++;
        end
        check("midreset_reached_access", 32'(bus.penable), 32'h1);
        @(posedge hclk); #2 hresetn = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge hclk) hresetn = 1'b1;
        @(posedge hclk); #1;
        check("post_reset_hreadyout", 32'(bus.hreadyout), 32'h1);
        check("post_reset_pselx", 32'(bus.pselx), 32'h0);
        check("post_reset_penable", 32'(bus.penable), 32'h0);

        add_txn(1'b1, 32'h8000_0010, 32'hABCD_1234, 32'h0,         3'b001, 0, 1'b0);
        add_txn(1'b0, 32'h8400_0020, 32'h0,         32'h1234_5678, 3'b010, 3, 1'b0);
        add_txn(1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_0003, 3'b100, 0, 1'b1);
        add_txn(1'b0, 32'h0000_0200, 32'h0,         32'hDEAD_0004, 3'b001, 4, 1'b0);
        add_txn(1'b0, 32'h0000_0300, 32'h0,         32'hCAFE_0005, 3'b001, 3, 1'b0);
        add_txn(1'b0, 32'h0000_0400, 32'h0,         32'h1111_0006, 3'b010, 0, 1'b0);
        add_txn(1'b0, 32'h0000_0404, 32'h0,         32'h2222_0007, 3'b010, 0, 1'b0);
        add_txn(1'b1, 32'h0000_0500, 32'h7777_0008, 32'h0,         3'b000, 0, 1'b0);
        add_txn(1'b1, 32'h0000_0600, 32'h5A5A_0009, 32'h0,         3'b100, 2, 1'b1);
        n_directed = plan.size();
        for (int i = 0; i < 60; i++) begin
            t.write  = 1'($urandom_range(0, 1));
            t.addr   = $urandom();
            t.wdata  = $urandom();
            t.rdata  = $urandom();
            k        = int'($urandom_range(0, 7));
            t.sel    = (k == 0) ? 3'b000 : 3'(1 << (k % 3));
            t.nwait  = int'($urandom_range(0, 6));
            t.slverr = ($urandom_range(0, 4) == 0);
            plan.push_back(t);
        end

        mon_en     = 1'b1;
        acc_cnt    = 0;
        last_wr    = 1'b0;
        last_wdata = 32'h0;
        issued     = 0;
        cycles     = 0;
        while ((plan.size() > 0 || resp_q.size() > 0) && cycles < MAX_CYCLES) begin
            @(posedge hclk); #1;
            cycles++;
            if (bus.penable) begin
                acc_cnt++;
                bus.pready  = (acc_cnt > cur.nwait);
                bus.pslverr = bus.pready ? cur.slverr : 1'($urandom_range(0, 1));
                bus.prdata  = bus.pready ? cur.rdata : $urandom();
            end else begin
                acc_cnt     = 0;
                bus.pready  = 1'($urandom_range(0, 1));
                bus.pslverr = 1'($urandom_range(0, 1));
                bus.prdata  = $urandom();
            end
            bus.hwdata = last_wr ? last_wdata : $urandom();
            last_wr    = 1'b0;
            #1;
            if (bus.hreadyout && plan.size() > 0 &&
                (issued < n_directed || $urandom_range(0, 3) != 0)) begin
                t             = plan.pop_front();
                cur           = t;
                issued++;
                bus.valid     = 1'b1;
                bus.hwrite    = t.write;
                bus.haddr1    = t.addr;
                bus.temp_selx = t.sel;
                e = model(t, cyc);
                resp_q.push_back(e);
                if (t.sel != 3'b000) apb_q.push_back(e);
                last_wr    = t.write;
                last_wdata = t.wdata;
            end else begin
                bus.valid     = 1'b0;
                bus.hwrite    = 1'($urandom_range(0, 1));
                bus.haddr1    = $urandom();
                bus.temp_selx = 3'($urandom());
            end
        end
        bus.valid = 1'b0;
        @(negedge hclk);
        check("finished_within_budget", 32'(cycles < MAX_CYCLES), 32'h1);
        check("resp_queue_drained", 32'(resp_q.size()), 32'h0);
        check("apb_queue_drained", 32'(apb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
